// File: rtl/err_power_meter_if.sv
// Measurement bus for err_power_meter: window control, packed error samples
// and the published per-channel mean/peak results.
interface err_power_meter_if #(
  parameter int W        = 18,
  parameter int LOG2_LEN = 20,
  parameter int NCH      = 2
);
  logic                clk_en;
  logic                start;
  logic                abort;
  logic                continuous;
  logic                mode;
  logic [NCH*W-1:0]    err;
  logic [NCH*W-1:0]    mean_out;
  logic [NCH*W-1:0]    peak_out;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic [LOG2_LEN-1:0] sample_cnt;

  modport master (
    output clk_en, start, abort, continuous, mode, err,
    input  mean_out, peak_out, busy, done, result_valid, sample_cnt
  );

  modport slave (
    input  clk_en, start, abort, continuous, mode, err,
    output mean_out, peak_out, busy, done, result_valid, sample_cnt
  );
endinterface

// File: rtl/err_power_meter.sv
// Windowed per-channel error power meter: mean squared or mean absolute error
// over 2^LOG2_LEN accepted samples, plus the peak magnitude of each window.
module err_power_meter #(
  parameter int W        = 18,
  parameter int LOG2_LEN = 20,
  parameter int NCH      = 2
) (
  input logic          clk,
  input logic          reset,
  err_power_meter_if.slave bus
);
  localparam int AW = W + LOG2_LEN;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [AW-1:0]       acc_q [NCH];
  logic [AW-1:0]       acc_d [NCH];
  logic [W-1:0]        peak_q [NCH];
  logic [W-1:0]        peak_d [NCH];
  logic [LOG2_LEN-1:0] cnt_q, cnt_d;
  logic [NCH*W-1:0]    mean_out_q, mean_out_d;
  logic [NCH*W-1:0]    peak_out_q, peak_out_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  logic [W-1:0]        raw     [NCH];
  logic [2*W-1:0]      ext     [NCH];
  logic [W-1:0]        sqTerm  [NCH];
  logic [W-1:0]        absSat  [NCH];
  logic [W-1:0]        term    [NCH];
  logic [AW-1:0]       accSum  [NCH];
  logic [W-1:0]        peakNew [NCH];

  logic accept;
  logic winEnd;
  logic clearWin;

  // The square is taken modulo 2^(2W) on sign-extended operands, which equals
  // the signed product; the most negative input squares to 2^(W-1) unwrapped.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      raw[k]     = bus.err[k*W +: W];
      ext[k]     = {{W{raw[k][W-1]}}, raw[k]};
      sqTerm[k]  = W'((ext[k] * ext[k]) >> (W-1));
      if (raw[k] == MIN_NEG)
        absSat[k] = MAX_POS;
      else if (raw[k][W-1])
        absSat[k] = ~raw[k] + W'(1);
      else
        absSat[k] = raw[k];
      term[k]    = mode_q ? absSat[k] : sqTerm[k];
      accSum[k]  = acc_q[k] + AW'(term[k]);
      peakNew[k] = (absSat[k] > peak_q[k]) ? absSat[k] : peak_q[k];
    end
  end

  assign accept = (state_q == ACCUM) && bus.clk_en;
  assign winEnd = accept && (cnt_q == '1);

  // Priority: abort, then window end (which may also restart), then start.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    cnt_d      = cnt_q;
    mean_out_d = mean_out_q;
    peak_out_d = peak_out_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    clearWin   = 1'b0;

    if (bus.abort) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      clearWin = 1'b1;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        state_d  = ACCUM;
        mode_d   = bus.mode;
        valid_d  = 1'b0;
        clearWin = 1'b1;
      end
    end else if (winEnd) begin
      for (int k = 0; k < NCH; k++) begin
        mean_out_d[k*W +: W] = accSum[k][AW-1:LOG2_LEN];
        peak_out_d[k*W +: W] = peakNew[k];
      end
      done_d   = 1'b1;
      valid_d  = 1'b1;
      clearWin = 1'b1;
      if (bus.start || bus.continuous)
        mode_d = bus.mode;
      else
        state_d = IDLE;
    end else if (bus.start) begin
      mode_d   = bus.mode;
      valid_d  = 1'b0;
      clearWin = 1'b1;
    end else if (accept) begin
      acc_d  = accSum;
      peak_d = peakNew;
      cnt_d  = cnt_q + LOG2_LEN'(1);
    end

    if (clearWin) begin
      for (int k = 0; k < NCH; k++) begin
        acc_d[k]  = '0;
        peak_d[k] = '0;
      end
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      mean_out_q <= '0;
      peak_out_q <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        acc_q[k]  <= '0;
        peak_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      mean_out_q <= mean_out_d;
      peak_out_q <= peak_out_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      for (int k = 0; k < NCH; k++) begin
        acc_q[k]  <= acc_d[k];
        peak_q[k] <= peak_d[k];
      end
    end
  end

  assign bus.mean_out     = mean_out_q;
  assign bus.peak_out     = peak_out_q;
  assign bus.busy         = (state_q == ACCUM);
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.sample_cnt   = cnt_q;
endmodule

// File: tb/tb_err_power_meter.sv
// Bench for err_power_meter: a window-level reference model checked every
// cycle, directed scenarios with literal results, then randomized traffic.
module tb_err_power_meter;
  localparam int W   = 18;
  localparam int L   = 4;
  localparam int NCH = 2;
  localparam int LEN = 1 << L;
  localparam longint MAXP = (64'sd1 << (W-1)) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  err_power_meter_if #(.W(W), .LOG2_LEN(L), .NCH(NCH)) bus ();

  err_power_meter #(.W(W), .LOG2_LEN(L), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the window is kept as a list of raw samples and the
  // result is computed from scratch when the window completes.
  bit                 mAccum = 0;
  bit                 mMode = 0;
  logic [NCH*W-1:0]   winQ [$];
  logic [NCH*W-1:0]   eMean = '0;
  logic [NCH*W-1:0]   ePeak = '0;
  bit                 eDone = 0;
  bit                 eValid = 0;

  function automatic longint satAbs(input logic [W-1:0] e);
    longint v;
    v = $signed(e);
    if (v < 0) v = -v;
    if (v > MAXP) v = MAXP;
    return v;
  endfunction

  function automatic longint sqOf(input logic [W-1:0] e);
    longint v;
    v = $signed(e);
    return (v * v) >>> (W-1);
  endfunction

  task automatic publish();
    for (int ch = 0; ch < NCH; ch++) begin
      longint sum = 0;
      longint pk = 0;
      foreach (winQ[i]) begin
        logic [W-1:0] e;
        e = winQ[i][ch*W +: W];
        sum += mMode ? satAbs(e) : sqOf(e);
        if (satAbs(e) > pk) pk = satAbs(e);
      end
      eMean[ch*W +: W] = W'(sum >> L);
      ePeak[ch*W +: W] = W'(pk);
    end
  endtask

  task automatic modelStep();
    eDone = 0;
    if (bus.abort) begin
      mAccum = 0;
      winQ.delete();
      eValid = 0;
    end else if (!mAccum) begin
      if (bus.start) begin
        mAccum = 1;
        mMode = bus.mode;
        winQ.delete();
        eValid = 0;
      end
    end else if (bus.clk_en && winQ.size() == LEN-1) begin
      winQ.push_back(bus.err);
      publish();
      eDone = 1;
      eValid = 1;
      winQ.delete();
      if (bus.start || bus.continuous) mMode = bus.mode;
      else mAccum = 0;
    end else if (bus.start) begin
      winQ.delete();
      mMode = bus.mode;
      eValid = 0;
    end else if (bus.clk_en) begin
      winQ.push_back(bus.err);
    end
  endtask

  // Advance the model on each edge, then compare once the DUT has settled.
  always @(posedge clk) begin
    if (reset) begin
      mAccum = 0;
      mMode = 0;
      winQ.delete();
      eMean = '0;
      ePeak = '0;
      eDone = 0;
      eValid = 0;
    end else begin
      modelStep();
    end
    #1;
    checkOutput("mean_out", bus.mean_out, eMean);
    checkOutput("peak_out", bus.peak_out, ePeak);
    checkOutput("busy", bus.busy, mAccum);
    checkOutput("done", bus.done, eDone);
    checkOutput("result_valid", bus.result_valid, eValid);
    checkOutput("sample_cnt", bus.sample_cnt, winQ.size() % LEN);
  end

  bit curCont = 0;
  bit curMode = 0;

  task automatic applyStimulus(input bit st, input bit ab, input bit en, input logic [NCH*W-1:0] e);
    bus.start      = st;
    bus.abort      = ab;
    bus.continuous = curCont;
    bus.mode       = curMode;
    bus.clk_en     = en;
    bus.err        = e;
    @(negedge clk);
  endtask

  task automatic feed(input logic [NCH*W-1:0] e);
    applyStimulus(0, 0, 1, e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mean"}, bus.mean_out, '0);
    checkOutput({tag, "_peak"}, bus.peak_out, '0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_valid"}, bus.result_valid, 0);
    checkOutput({tag, "_cnt"}, bus.sample_cnt, 0);
  endtask

  function automatic logic [NCH*W-1:0] randErr();
    logic [NCH*W-1:0] v;
    for (int ch = 0; ch < NCH; ch++) begin
      case ($urandom_range(0, 9))
        0:       v[ch*W +: W] = {1'b1, {(W-1){1'b0}}};
        1:       v[ch*W +: W] = {1'b0, {(W-1){1'b1}}};
        default: v[ch*W +: W] = W'($urandom);
      endcase
    end
    return v;
  endfunction

  initial begin
    int doneCount;
    int lastDone;
    int gapBad;
    bit busyDrop;

    bus.start = 0; bus.abort = 0; bus.continuous = 0; bus.mode = 0;
    bus.clk_en = 0; bus.err = '0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    applyStimulus(0, 0, 1, '0);
    checkOutput("idle_clken_busy", bus.busy, 0);

    // Mean squared error of a constant half-scale input.
    curMode = 0;
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < LEN; i++) feed({18'h10000, 18'h10000});
    checkOutput("mse_done", bus.done, 1);
    checkOutput("mse_mean", bus.mean_out, {18'h08000, 18'h08000});
    checkOutput("mse_peak", bus.peak_out, {18'h10000, 18'h10000});
    checkOutput("mse_busy", bus.busy, 0);
    applyStimulus(0, 0, 0, '0);
    checkOutput("mse_done_pulse", bus.done, 0);
    checkOutput("mse_valid_hold", bus.result_valid, 1);

    // Mean absolute error with the most negative input saturating.
    curMode = 1;
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < LEN; i++)
      feed({(i % 2 == 0) ? 18'h04000 : 18'h3C000, 18'h20000});
    checkOutput("mae_mean", bus.mean_out, {18'h04000, 18'h1FFFF});
    checkOutput("mae_peak", bus.peak_out, {18'h04000, 18'h1FFFF});

    // Same data squared; the mode input toggles mid-window and must be ignored.
    curMode = 0;
    applyStimulus(1, 0, 0, '0);
    curMode = 1;
    for (int i = 0; i < LEN; i++)
      feed({(i % 2 == 0) ? 18'h04000 : 18'h3C000, 18'h20000});
    checkOutput("mse_neg_mean", bus.mean_out, {18'h00800, 18'h20000});

    // Abort part way through a second window keeps the last published result.
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < 7; i++) feed(randErr());
    checkOutput("abort_cnt7", bus.sample_cnt, 7);
    applyStimulus(0, 1, 1, randErr());
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_valid", bus.result_valid, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_mean_kept", bus.mean_out, {18'h00800, 18'h20000});
    applyStimulus(1, 1, 0, '0);
    checkOutput("abort_start_busy", bus.busy, 0);

    // Restart at sample 9: only the final 16 samples contribute.
    curMode = 1;
    doneCount = 0;
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < 8; i++) feed({18'h10000, 18'h10000});
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < LEN; i++) begin
      feed({18'h00100, 18'h00100});
      if (bus.done) doneCount++;
    end
    checkOutput("restart_single_done", doneCount, 1);
    checkOutput("restart_mean", bus.mean_out, {18'h00100, 18'h00100});
    checkOutput("restart_peak", bus.peak_out, {18'h00100, 18'h00100});

    // Continuous windows with a sample every other clock.
    curCont = 1;
    curMode = 0;
    doneCount = 0;
    lastDone = -1;
    gapBad = 0;
    busyDrop = 0;
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < 3*2*LEN; i++) begin
      applyStimulus(0, 0, (i % 2 == 0), randErr());
      if (!bus.busy) busyDrop = 1;
      checkOutput("cont_cnt", bus.sample_cnt, ((i >> 1) + 1) % LEN);
      if (bus.done) begin
        if (lastDone >= 0 && i - lastDone != 2*LEN) gapBad++;
        lastDone = i;
        doneCount++;
      end
    end
    checkOutput("cont_done_count", doneCount, 3);
    checkOutput("cont_done_gap", gapBad, 0);
    checkOutput("cont_busy_held", busyDrop, 0);
    curCont = 0;
    applyStimulus(0, 1, 0, '0);

    // Asynchronous reset in the middle of a window.
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) feed(randErr());
    #2 reset = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) feed(randErr());
    checkAllZero("post_reset");

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) curCont = ~curCont;
      curMode = $urandom_range(0, 1);
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        applyStimulus(0, 0, 1, randErr());
        reset = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
                      $urandom_range(0, 3) != 0, randErr());
      end
    end
    applyStimulus(0, 0, 0, '0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/err_power_meter.md
ERR_POWER_METER -- requirements
Module: err_power_meter

Interface
REQ-001 Parameter W, default 18, signed error sample width per channel (1sW-1 format).
REQ-002 Parameter LOG2_LEN, default 20, window length exponent; window = 2^LOG2_LEN accepted samples; legal range 1..24.
REQ-003 Parameter NCH, default 2, number of independent error channels (I/Q by default).
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high; clock clk.
REQ-006 clk_en  input  1  sample strobe; a sample is accepted only on clk edges with clk_en=1.
REQ-007 start  input  1  single-cycle request to begin a measurement window.
REQ-008 abort  input  1  single-cycle request to cancel the current window.
REQ-009 continuous  input  1  when 1, a new window begins automatically at each window end.
REQ-010 mode  input  1  0 = mean squared error, 1 = mean absolute error.
REQ-011 err  input  NCH*W  packed signed samples; channel k occupies bits [k*W+W-1:k*W].
REQ-012 mean_out  output  NCH*W  packed unsigned per-channel window means, same packing.
REQ-013 peak_out  output  NCH*W  packed unsigned per-channel peak magnitude of the last window.
REQ-014 busy  output  1  high while a window is accumulating.
REQ-015 done  output  1  one-clk pulse when mean_out/peak_out update.
REQ-016 result_valid  output  1  high from first done until next start, abort or reset.
REQ-017 sample_cnt  output  LOG2_LEN  accepted samples in the current window.

Function
REQ-018 FSM states IDLE, ACCUM; IDLE->ACCUM on start; ACCUM->IDLE on abort, or on window end with continuous=0; ACCUM->ACCUM on window end with continuous=1.
REQ-019 mode is latched on entry to ACCUM (including automatic restarts) and held for the whole window; mode changes mid-window have no effect.
REQ-020 Square term: 2W-bit product err*err, term = product[2W-2:W-1], unsigned W bits; -2^(W-1) yields 2^(W-1) without wrap.
REQ-021 Absolute term: |err| as unsigned W bits; -2^(W-1) saturates to 2^(W-1)-1.
REQ-022 Per-channel accumulator unsigned, W+LOG2_LEN bits; cleared on entry to ACCUM; cannot overflow for any input.
REQ-023 In ACCUM, each accepted sample adds its term to every channel accumulator, updates the per-channel running peak of |err| (saturated per REQ-021) and increments sample_cnt.
REQ-024 Window ends on the clk edge accepting sample 2^LOG2_LEN; that same edge loads mean_out = (acc+term)[W+LOG2_LEN-1:LOG2_LEN] and peak_out including the final sample; sample_cnt wraps to 0.
REQ-025 done is high for exactly the one clk cycle following the window-end edge, regardless of clk_en; result_valid rises with it.
REQ-026 Automatic restart (continuous=1) clears accumulators and peaks on the window-end edge itself; the next accepted sample counts as sample 1 of the new window; no sample is lost.
REQ-027 start while in ACCUM restarts the window: accumulators, peaks, sample_cnt cleared; mean_out/peak_out unchanged; no done.
REQ-028 abort has priority over start and window end on the same edge: FSM to IDLE, accumulators, peaks, sample_cnt cleared, result_valid cleared, mean_out/peak_out retained, no done.
REQ-029 start and window end on the same edge: result is published (done next cycle) and a new window begins.
REQ-030 clk_en=1 in IDLE has no effect on any state.
REQ-031 busy = 1 exactly when FSM is ACCUM.

Reset
REQ-032 On reset assertion all outputs go to 0 immediately: mean_out, peak_out, busy, done, result_valid, sample_cnt; FSM IDLE; accumulators and peaks 0.
REQ-033 Reset deasserted mid-window leaves the block in IDLE; no partial result is ever published.

Verification
REQ-034 W=18, LOG2_LEN=4, NCH=2, mode=0, 16 samples err={0x10000,0x10000} -> done one cycle after 16th sample, mean_out={0x08000,0x08000}, peak_out={0x10000,0x10000}.
REQ-035 Same, mode=1, ch0=-2^17 constant, ch1 alternating +/-0x04000 -> mean ch0=0x1FFFF, ch1=0x04000; mode=0 ch0 mean=0x20000.
REQ-036 continuous=1, clk_en every other cycle, 3 windows -> three done pulses exactly 32 clk apart, busy never drops, sample_cnt 0..15 repeating.
REQ-037 abort after 7 samples of a second window -> busy=0, result_valid=0, mean_out keeps first-window value, no done; abort+start same cycle -> IDLE.
REQ-038 start at sample 9 then 16 further samples -> single done, mean reflects only the last 16 samples; reset asserted mid-window -> all outputs 0 asynchronously.
